// File: rtl/shared_mem_arbiter_if.sv
// rtl/shared_mem_arbiter_if.sv - fetch/data requester and shared memory port bundle
interface shared_mem_arbiter_if #(
    parameter int NBITS = 64
);
    logic             if_req;
    logic [NBITS-1:0] if_addr;
    logic             if_ack;
    logic [31:0]      if_rdata;
    logic             d_req;
    logic             d_we;
    logic [NBITS-1:0] d_addr;
    logic [NBITS-1:0] d_wdata;
    logic             d_ack;
    logic [NBITS-1:0] d_rdata;
    logic             mem_en;
    logic             mem_we;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic [NBITS-1:0] mem_rdata;
    logic             busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin arbiter of fetch and load/store onto one memory port
module shared_mem_arbiter #(
    parameter int Nbits   = 64,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    shared_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic             last_fetch;
    logic [3:0]       lat_cnt;
    logic             take;
    logic             grant_fetch;
    logic             grant_we;
    logic [Nbits-1:0] grant_addr;
    logic [Nbits-1:0] grant_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On a tie the port that did not win last time is granted.
    always_comb begin
        state_next  = state;
        take        = 1'b0;
        grant_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    take        = 1'b1;
                    grant_fetch = bus.if_req && (!bus.d_req || !last_fetch);
                    state_next  = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (lat_cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        grant_addr  = grant_fetch ? bus.if_addr : bus.d_addr;
        grant_wdata = grant_fetch ? '0 : bus.d_wdata;
        grant_we    = !grant_fetch && bus.d_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_fetch    <= 1'b0;
            lat_cnt       <= '0;
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
        end else begin
            bus.busy   <= (state_next != IDLE);
            bus.mem_en <= take;
            bus.mem_we <= take && grant_we;
            // Address and data are latched at grant so requester changes mid-transfer are ignored.
            if (take) begin
                last_fetch    <= grant_fetch;
                bus.mem_addr  <= grant_addr;
                bus.mem_wdata <= grant_wdata;
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (state == WAIT && lat_cnt == 4'd0) begin
                if (last_fetch) begin
                    bus.if_rdata <= bus.mem_rdata[31:0];
                end else begin
                    bus.d_rdata <= bus.mem_rdata;
                end
            end
            bus.if_ack <= (state_next == RESP) && last_fetch;
            bus.d_ack  <= (state_next == RESP) && !last_fetch;
        end
    end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - directed bench for shared_mem_arbiter at MEM_LAT 2, 1 and 15
module tb_shared_mem_arbiter;
    localparam int NB = 64;

    typedef struct {
        int          inst;
        bit          ifr;
        bit          dr;
        bit          we;
        logic [63:0] ia;
        logic [63:0] da;
        logic [63:0] wd;
        logic [63:0] mv;
        bit          exp_d;
        bit          exp_we;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        bit          chk_rd;
        logic [63:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req_a[3];
    logic        d_req_a[3];
    logic        d_we_a[3];
    logic [63:0] if_addr_a[3];
    logic [63:0] d_addr_a[3];
    logic [63:0] d_wdata_a[3];
    logic [63:0] rd_val[3];
    logic        if_ack_a[3];
    logic        d_ack_a[3];
    logic        mem_en_a[3];
    logic        mem_we_a[3];
    logic        busy_a[3];
    logic [31:0] if_rdata_a[3];
    logic [63:0] d_rdata_a[3];
    logic [63:0] mem_addr_a[3];
    logic [63:0] mem_wdata_a[3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        shared_mem_arbiter_if #(.NBITS(NB)) bus ();
        logic [63:0] rdata_drv = '0;
        logic        en_s;
        int          t = -1;

        shared_mem_arbiter #(.Nbits(NB), .MEM_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.if_req    = if_req_a[g];
        assign bus.if_addr   = if_addr_a[g];
        assign bus.d_req     = d_req_a[g];
        assign bus.d_we      = d_we_a[g];
        assign bus.d_addr    = d_addr_a[g];
        assign bus.d_wdata   = d_wdata_a[g];
        assign bus.mem_rdata = rdata_drv;
        assign if_ack_a[g]    = bus.if_ack;
        assign d_ack_a[g]     = bus.d_ack;
        assign mem_en_a[g]    = bus.mem_en;
        assign mem_we_a[g]    = bus.mem_we;
        assign busy_a[g]      = bus.busy;
        assign if_rdata_a[g]  = bus.if_rdata;
        assign d_rdata_a[g]   = bus.d_rdata;
        assign mem_addr_a[g]  = bus.mem_addr;
        assign mem_wdata_a[g] = bus.mem_wdata;

        // Memory model: read data is valid only in the single cycle LAT cycles after mem_en.
        always begin
            @(posedge clk);
            en_s = bus.mem_en;
            #1;
            if (en_s) t = LAT - 1;
            else if (t > 0) t = t - 1;
            else t = -1;
            rdata_drv = (t == 0) ? rd_val[g] : 64'hBAD0_0BAD_BAD0_0BAD;
        end
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            if_req_a[i]  = 1'b0;
            d_req_a[i]   = 1'b0;
            d_we_a[i]    = 1'b0;
            if_addr_a[i] = '0;
            d_addr_a[i]  = '0;
            d_wdata_a[i] = '0;
            rd_val[i]    = '0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_vec(input vec_t v, input string nm);
        int          g = v.inst;
        int          lat = lat_of(v.inst);
        int          ack_cyc = -1;
        int          ack_cnt = 0;
        int          en_cnt = 0;
        int          en_cyc = -1;
        int          both = 0;
        int          busy_bad = 0;
        bit          ack_d = 1'b0;
        logic        mw = 1'b0;
        logic [63:0] ma = '0;
        logic [63:0] mwd = '0;
        logic [63:0] rd = '0;
        if_req_a[g]  = v.ifr;
        d_req_a[g]   = v.dr;
        d_we_a[g]    = v.we;
        if_addr_a[g] = v.ia;
        d_addr_a[g]  = v.da;
        d_wdata_a[g] = v.wd;
        rd_val[g]    = v.mv;
        for (int n = 1; n <= lat + 8; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                if_addr_a[g] = ~v.ia;
                d_addr_a[g]  = ~v.da;
                d_wdata_a[g] = ~v.wd;
                d_we_a[g]    = ~v.we;
            end
            if (mem_en_a[g]) begin
                en_cnt++;
                en_cyc = n;
                mw  = mem_we_a[g];
                ma  = mem_addr_a[g];
                mwd = mem_wdata_a[g];
            end
            if (if_ack_a[g] && d_ack_a[g]) both++;
            if (if_ack_a[g] || d_ack_a[g]) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc = n;
                    ack_d   = d_ack_a[g];
                    rd      = d_ack_a[g] ? d_rdata_a[g] : {32'h0, if_rdata_a[g]};
                end
                if_req_a[g] = 1'b0;
                d_req_a[g]  = 1'b0;
            end
            if (busy_a[g] !== (n <= lat + 2)) busy_bad++;
        end
        check({nm, "_ack_cycle"}, 64'(ack_cyc), 64'(lat + 2));
        check({nm, "_ack_count"}, 64'(ack_cnt), 64'd1);
        check({nm, "_ack_port"}, 64'(ack_d), 64'(v.exp_d));
        check({nm, "_both_ack"}, 64'(both), 64'd0);
        check({nm, "_en_count"}, 64'(en_cnt), 64'd1);
        check({nm, "_en_cycle"}, 64'(en_cyc), 64'd1);
        check({nm, "_mem_we"}, 64'(mw), 64'(v.exp_we));
        check({nm, "_mem_addr"}, ma, v.exp_addr);
        check({nm, "_mem_wdata"}, mwd, v.exp_wdata);
        check({nm, "_busy"}, 64'(busy_bad), 64'd0);
        if (v.chk_rd) check({nm, "_rdata"}, rd, v.exp_rd);
    endtask

    vec_t vt[9];

    initial begin
        int          acks;
        int          ack_cnt;
        int          en_cnt;
        int          both;
        logic [3:0]  seq;
        logic [63:0] ea[4];
        int          ac[4];

        vt[0] = '{0, 1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'h00A00093,
                  1'b0, 1'b0, 64'h10, 64'h0, 1'b1, 64'h00A00093};
        vt[1] = '{0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h200, 64'hDEADBEEF, 64'h5555,
                  1'b1, 1'b1, 64'h200, 64'hDEADBEEF, 1'b0, 64'h0};
        vt[2] = '{0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h208, 64'h77, 64'h0123456789ABCDEF,
                  1'b1, 1'b0, 64'h208, 64'h77, 1'b1, 64'h0123456789ABCDEF};
        vt[3] = '{0, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h999, 64'hABCD, 64'hCAFEBABE12345678,
                  1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 1'b1, 64'h12345678};
        vt[4] = '{1, 1'b1, 1'b0, 1'b0, 64'h20, 64'h0, 64'h0, 64'h13,
                  1'b0, 1'b0, 64'h20, 64'h0, 1'b1, 64'h13};
        vt[5] = '{1, 1'b0, 1'b1, 1'b1, 64'h0, 64'h1F8, 64'h1122334455667788, 64'h0,
                  1'b1, 1'b1, 64'h1F8, 64'h1122334455667788, 1'b0, 64'h0};
        vt[6] = '{2, 1'b0, 1'b1, 1'b0, 64'h0, 64'h400, 64'h0, 64'hA5A5A5A5A5A5A5A5,
                  1'b1, 1'b0, 64'h400, 64'h0, 1'b1, 64'hA5A5A5A5A5A5A5A5};
        vt[7] = '{2, 1'b1, 1'b0, 1'b0, 64'h44, 64'h0, 64'h0, 64'hFFFFFFFF00000037,
                  1'b0, 1'b0, 64'h44, 64'h0, 1'b1, 64'h37};
        vt[8] = '{0, 1'b1, 1'b0, 1'b0, 64'h84, 64'h0, 64'h0, 64'h00100073,
                  1'b0, 1'b0, 64'h84, 64'h0, 1'b1, 64'h00100073};

        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({busy_a[0], mem_en_a[0], mem_we_a[0], if_ack_a[0], d_ack_a[0]}), 64'd0);
        check("reset_mem_addr", mem_addr_a[0], 64'd0);
        check("reset_d_rdata", d_rdata_a[0], 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) do_vec(vt[i], $sformatf("vec%0d", i));

        // Reset in the middle of a fetch's WAIT phase.
        if_req_a[0]  = 1'b1;
        if_addr_a[0] = 64'h80;
        rd_val[0]    = 64'h1234567800000013;
        @(posedge clk);
        #1;
        check("midrst_issue_en", 64'(mem_en_a[0]), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ctrl", 64'({busy_a[0], mem_en_a[0], mem_we_a[0], if_ack_a[0], d_ack_a[0]}), 64'd0);
        check("midrst_if_rdata", 64'(if_rdata_a[0]), 64'd0);
        check("midrst_d_rdata", d_rdata_a[0], 64'd0);
        check("midrst_mem_addr", mem_addr_a[0], 64'd0);
        acks = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            if (if_ack_a[0] || d_ack_a[0] || mem_en_a[0]) acks++;
        end
        check("midrst_no_ack", 64'(acks), 64'd0);
        rst = 1'b0;
        do_vec(vt[8], "post_rst");

        // Both requesters held: fetch wins the first tie after reset, then strict alternation.
        do_reset();
        if_req_a[0]  = 1'b1;
        if_addr_a[0] = 64'h40;
        d_req_a[0]   = 1'b1;
        d_we_a[0]    = 1'b0;
        d_addr_a[0]  = 64'h300;
        rd_val[0]    = 64'h5A;
        ack_cnt = 0;
        en_cnt  = 0;
        both    = 0;
        seq     = '0;
        for (int i = 0; i < 4; i++) begin
            ea[i] = '0;
            ac[i] = -1;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (mem_en_a[0]) begin
                if (en_cnt < 4) ea[en_cnt] = mem_addr_a[0];
                en_cnt++;
            end
            if (if_ack_a[0] && d_ack_a[0]) both++;
            if (if_ack_a[0] || d_ack_a[0]) begin
                seq = {seq[2:0], d_ack_a[0]};
                if (ack_cnt < 4) ac[ack_cnt] = n;
                ack_cnt++;
                if (ack_cnt == 4) begin
                    if_req_a[0] = 1'b0;
                    d_req_a[0]  = 1'b0;
                end
            end
        end
        check("tie_ack_count", 64'(ack_cnt), 64'd4);
        check("tie_order", 64'(seq), 64'b0101);
        check("tie_en_count", 64'(en_cnt), 64'd4);
        check("tie_both_ack", 64'(both), 64'd0);
        check("tie_addr0", ea[0], 64'h40);
        check("tie_addr1", ea[1], 64'h300);
        check("tie_addr2", ea[2], 64'h40);
        check("tie_ack0_cycle", 64'(ac[0]), 64'd4);
        check("tie_ack1_cycle", 64'(ac[1]), 64'd9);
        check("tie_ack3_cycle", 64'(ac[3]), 64'd19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
